// File: rtl/mag_comp_pkg.sv
// Shared types and helpers for the cascaded magnitude comparator.
// Slice width, the comparison result encoding and its mapping onto the three output flags.
package mag_comp_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_e;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_flags_t;

  // Exactly one flag is set for any legal result; an illegal encoding yields all zeros.
  function automatic cmp_flags_t cmp_to_flags(input cmp_e res);
    cmp_flags_t f;
    f = '0;
    unique case (res)
      CMP_GT:  f.gt = 1'b1;
      CMP_LT:  f.lt = 1'b1;
      CMP_EQ:  f.eq = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mag_comp_slice.sv
// Combinational 4-bit magnitude comparator slice with 7485-style cascade inputs.
// The cascade comes from the next more-significant slice; a decided result passes straight through.
module mag_comp_slice
  import mag_comp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               gt_in,
  input  logic               lt_in,
  input  logic               eq_in,
  output logic               gt,
  output logic               lt,
  output logic               eq
);

  logic local_gt;
  logic local_lt;
  logic local_eq;

  always_comb begin
    local_gt = (a > b);
    local_lt = (a < b);
    local_eq = (a == b);
  end

  // This slice only gets a say while everything above it compared equal.
  always_comb begin
    gt = gt_in | (eq_in & local_gt);
    lt = lt_in | (eq_in & local_lt);
    eq = eq_in & local_eq;
  end

endmodule

// File: rtl/mag_comp.sv
// Registered WIDTH-bit magnitude comparator built from a MSB-first cascade of 4-bit slices.
// Define MAG_COMP_SIGNED_EN to compare A and B as two's-complement values (default: unsigned).
module mag_comp
  import mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             out_valid
);

  // WIDTH must be a non-zero multiple of SLICE_W.
  localparam int unsigned NumSlices = WIDTH / SLICE_W;

  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;

`ifdef MAG_COMP_SIGNED_EN
  // Flipping both sign bits maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SignMask = {1'b1, {(WIDTH - 1){1'b0}}};
  assign a_cmp = A ^ SignMask;
  assign b_cmp = B ^ SignMask;
`else
  assign a_cmp = A;
  assign b_cmp = B;
`endif

  for (genvar i = 0; i < NumSlices; i++) begin : g_slice
    logic gt_in;
    logic lt_in;
    logic eq_in;
    logic gt;
    logic lt;
    logic eq;

    if (i == NumSlices - 1) begin : g_head
      assign gt_in = 1'b0;
      assign lt_in = 1'b0;
      assign eq_in = 1'b1;
    end else begin : g_link
      assign gt_in = g_slice[i+1].gt;
      assign lt_in = g_slice[i+1].lt;
      assign eq_in = g_slice[i+1].eq;
    end

    mag_comp_slice u_slice (
      .a     (a_cmp[i*SLICE_W +: SLICE_W]),
      .b     (b_cmp[i*SLICE_W +: SLICE_W]),
      .gt_in (gt_in),
      .lt_in (lt_in),
      .eq_in (eq_in),
      .gt    (gt),
      .lt    (lt),
      .eq    (eq)
    );
  end

  cmp_e       result;
  cmp_flags_t flags_d;

  always_comb begin
    if (g_slice[0].gt) begin
      result = CMP_GT;
    end else if (g_slice[0].lt) begin
      result = CMP_LT;
    end else begin
      result = CMP_EQ;
    end
    flags_d = cmp_to_flags(result);
  end

  logic gt_q;
  logic lt_q;
  logic eq_q;
  logic valid_q;

  // Flags hold across idle cycles; out_valid marks only the cycle after a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        gt_q <= flags_d.gt;
        lt_q <= flags_d.lt;
        eq_q <= flags_d.eq;
      end
    end
  end

  assign A_gt_B    = gt_q;
  assign A_lt_B    = lt_q;
  assign A_eq_B    = eq_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mag_comp.sv
// Directed, table-driven bench for mag_comp at WIDTH=4 and WIDTH=8.
// Expectations follow MAG_COMP_SIGNED_EN when it is defined for the build.
module tb_mag_comp;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] exp_u;  // {gt, lt, eq} unsigned
    logic [2:0] exp_s;  // {gt, lt, eq} two's complement
  } vec_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv4 = 1'b0;
  logic       iv8 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       gt4, lt4, eq4, ov4;
  logic       gt8, lt8, eq8, ov8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mag_comp u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .A         (a4),
    .B         (b4),
    .A_gt_B    (gt4),
    .A_lt_B    (lt4),
    .A_eq_B    (eq4),
    .out_valid (ov4)
  );

  mag_comp #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .A         (a8),
    .B         (b8),
    .A_gt_B    (gt8),
    .A_lt_B    (lt8),
    .A_eq_B    (eq8),
    .out_valid (ov8)
  );

  function automatic logic [2:0] exp_of(input vec_t v);
`ifdef MAG_COMP_SIGNED_EN
    return v.exp_s;
`else
    return v.exp_u;
`endif
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {gt,lt,eq,valid}=%b, expected %b", name, act, exp);
    end
  endtask

  vec_t t4[8];
  vec_t t8[6];

  initial begin
    t4[0] = '{8'h09, 8'h05, GT, LT};  // -7 vs +5
    t4[1] = '{8'h02, 8'h08, LT, GT};  // +2 vs -8
    t4[2] = '{8'h0C, 8'h0C, EQ, EQ};
    t4[3] = '{8'h00, 8'h00, EQ, EQ};
    t4[4] = '{8'h0F, 8'h00, GT, LT};  // -1 vs 0
    t4[5] = '{8'h0F, 8'h08, GT, GT};  // -1 vs -8
    t4[6] = '{8'h07, 8'h08, LT, GT};  // +7 vs -8
    t4[7] = '{8'h03, 8'h04, LT, LT};

    t8[0] = '{8'h80, 8'h7F, GT, LT};  // top slice decides
    t8[1] = '{8'h12, 8'h13, LT, LT};  // bottom slice decides
    t8[2] = '{8'hA5, 8'hA5, EQ, EQ};
    t8[3] = '{8'hFF, 8'h00, GT, LT};
    t8[4] = '{8'h34, 8'h43, LT, LT};
    t8[5] = '{8'hFE, 8'hFF, LT, LT};  // -2 vs -1

    // Reset state, and reset winning over a concurrent in_valid.
    repeat (2) @(negedge clk);
    check("reset4", {gt4, lt4, eq4, ov4}, 4'b0000);
    check("reset8", {gt8, lt8, eq8, ov8}, 4'b0000);
    a4 = 4'h9; b4 = 4'h5; iv4 = 1'b1;
    @(negedge clk);
    check("reset_wins", {gt4, lt4, eq4, ov4}, 4'b0000);
    iv4 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("no_capture_idle", {gt4, lt4, eq4, ov4}, 4'b0000);

    // Back-to-back 4-bit stream: one result per cycle, no bubbles.
    a4 = t4[0].a[3:0]; b4 = t4[0].b[3:0]; iv4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("w4_vec%0d", i), {gt4, lt4, eq4, ov4}, {exp_of(t4[i]), 1'b1});
      if (i < 7) begin
        a4 = t4[i+1].a[3:0]; b4 = t4[i+1].b[3:0];
      end else begin
        iv4 = 1'b0;
      end
    end

    // Idle cycles: flags hold the last result, out_valid low, new operands ignored.
    for (int i = 0; i < 3; i++) begin
      a4 = 4'(i + 5); b4 = 4'(i);
      @(negedge clk);
      check($sformatf("hold%0d", i), {gt4, lt4, eq4, ov4}, {exp_of(t4[7]), 1'b0});
    end

    // Back-to-back 8-bit stream.
    a8 = t8[0].a; b8 = t8[0].b; iv8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("w8_vec%0d", i), {gt8, lt8, eq8, ov8}, {exp_of(t8[i]), 1'b1});
      if (i < 5) begin
        a8 = t8[i+1].a; b8 = t8[i+1].b;
      end else begin
        iv8 = 1'b0;
      end
    end
    @(negedge clk);
    check("w8_idle", {gt8, lt8, eq8, ov8}, {exp_of(t8[5]), 1'b0});

    // Isolated capture, then a bubble, then another capture.
    a4 = t4[0].a[3:0]; b4 = t4[0].b[3:0]; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    check("single_cap", {gt4, lt4, eq4, ov4}, {exp_of(t4[0]), 1'b1});
    @(negedge clk);
    check("single_bubble", {gt4, lt4, eq4, ov4}, {exp_of(t4[0]), 1'b0});

    // Mid-cycle reset clears outputs before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_reset4", {gt4, lt4, eq4, ov4}, 4'b0000);
    check("async_reset8", {gt8, lt8, eq8, ov8}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    a4 = t4[2].a[3:0]; b4 = t4[2].b[3:0]; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    check("first_after_reset", {gt4, lt4, eq4, ov4}, {exp_of(t4[2]), 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
